// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, register map addresses and controller FSM states for the SPI write protocol
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int WRITE_BIT = 15;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0 = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0 = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY = 7'h04;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter whose zero state marks the last cycle of a phase
module spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == '0;
  // reload on every phase change, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 register-write initiator; define SPI_CTRL_ADDR_CHECK_EN to reject addresses above MAX_ADDR
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 7'h04
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              SCLK,
  output logic              nCS,
  output logic              COPI,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(HALF_PERIOD > GAP_CYCLES ? HALF_PERIOD : GAP_CYCLES);
  localparam logic [CW-1:0] HP_LD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  state_t state;
  logic [FRAME_W-1:0] sr, frame;
  logic [3:0] bit_cnt;
  logic [CW-1:0] cnt;
  logic tc, accept, bad, load;
  assign frame = {1'b1, req_addr, req_data};
  assign accept = req_valid && req_ready;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign bad = req_addr > MAX_ADDR;
`else
  assign bad = 1'b0;
`endif
  assign load = accept || (state != IDLE && tc);
  spi_phase_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(state == HOLD ? GAP_LD : HP_LD),
    .cnt(cnt),
    .tc(tc)
  );
  // frame sequencer; every pin is a register so SCLK/nCS/COPI never glitch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      req_ready <= 1'b1;
      SCLK <= 1'b0;
      nCS <= 1'b1;
      COPI <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= (state == HOLD && tc && GAP_CYCLES == 1) || (state == GAP && cnt == CW'(1));
      err <= accept && bad;
      case (state)
        IDLE: if (accept && !bad) begin
          state <= SETUP;
          sr <= frame;
          req_ready <= 1'b0;
          busy <= 1'b1;
          nCS <= 1'b0;
          COPI <= frame[WRITE_BIT];
        end
        SETUP, LOW: if (tc) begin
          state <= HIGH;
          SCLK <= 1'b1;
        end
        HIGH: if (tc) begin
          SCLK <= 1'b0;
          bit_cnt <= bit_cnt + 4'd1;
          state <= bit_cnt == 4'd15 ? HOLD : LOW;
          sr <= sr << 1;
          COPI <= bit_cnt == 4'd15 ? COPI : sr[FRAME_W-2];
        end
        HOLD: if (tc) begin
          state <= GAP;
          nCS <= 1'b1;
          COPI <= 1'b0;
        end
        GAP: if (tc) begin
          state <= IDLE;
          req_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed scoreboard bench with a loopback peripheral model for two timing configurations
module tb_spi_controller;
  import spi_pkg::*;
  logic clk = 0, rst = 1;
  logic [1:0] vld = '0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic [1:0] rdy, sclk, ncs, copi, busy, done, err;
  int passed = 0, total = 0;
  logic [15:0] expq0[$], expq1[$];
  logic [7:0] lb0[5], lb1[5];
  int r_ncs, r_sclk, r_done, r_low, r_wait, r_rdy, r_busy;
  always #5 clk = ~clk;
  spi_controller u0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_addr(addr), .req_data(data),
    .SCLK(sclk[0]), .nCS(ncs[0]), .COPI(copi[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );
  spi_controller #(.HALF_PERIOD(2), .GAP_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_addr(addr), .req_data(data),
    .SCLK(sclk[1]), .nCS(ncs[1]), .COPI(copi[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic frame_end(input int g, input logic [15:0] f);
    logic [15:0] e;
    chk("frame_pending", (g == 0 ? expq0.size() : expq1.size()) > 0, 1);
    if ((g == 0 ? expq0.size() : expq1.size()) > 0) begin
      e = g == 0 ? expq0.pop_front() : expq1.pop_front();
      chk("frame", f, e);
      if (f[15] && f[14:8] <= 7'd4) begin
        if (g == 0) lb0[f[14:8]] = f[7:0];
        else lb1[f[14:8]] = f[7:0];
      end
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : mon
    int bits = 0, frames = 0, hi = 0, hi_run = 0, viol = 0, errs = 0;
    logic [15:0] sh = '0;
    logic ps = 0, pn = 1, pc = 0;
    always @(negedge clk) begin
      if (!ncs[g] && sclk[g] && !ps) begin
        sh = {sh[14:0], copi[g]};
        bits++;
      end
      if (sclk[g] && ps && copi[g] !== pc) viol++;
      if (err[g]) errs++;
      if (!ncs[g] && pn) hi_run = hi;
      hi = ncs[g] ? hi + 1 : 0;
      if (ncs[g] && !pn) begin
        if (bits == 16) begin
          frames++;
          frame_end(g, sh);
        end
        bits = 0;
      end
      ps = sclk[g];
      pn = ncs[g];
      pc = copi[g];
    end
  end
  task automatic do_write(input int i, input logic [6:0] a, input logic [7:0] d, input bit hold);
    int w = 0;
    addr = a;
    data = d;
    vld[i] = 1'b1;
    while (!rdy[i] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    r_wait = w; r_ncs = -1; r_sclk = -1; r_done = -1; r_low = 0; r_rdy = 0; r_busy = 0;
    if (!rdy[i]) begin
      vld[i] = 1'b0;
      return;
    end
    if (i == 0) expq0.push_back({1'b1, a, d});
    else expq1.push_back({1'b1, a, d});
    @(posedge clk);
    #1 if (!hold) vld[i] = 1'b0;
    for (int n = 1; n <= 1000 && r_done < 0; n++) begin
      @(negedge clk);
      if (n == 1) r_busy = busy[i];
      if (!ncs[i]) begin
        r_low++;
        if (r_ncs < 0) r_ncs = n;
      end
      if (sclk[i] && r_sclk < 0) r_sclk = n;
      if (rdy[i]) r_rdy++;
      if (done[i]) r_done = n;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  initial begin
    int f0, n_low, n_done;
    logic [7:0] saved;
    for (int k = 0; k < 5; k++) begin
      lb0[k] = '0;
      lb1[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy, 2'b11);
    chk("rst_ncs", ncs, 2'b11);
    chk("rst_sclk", sclk, 2'b00);
    chk("rst_copi", copi, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 2'b00);
    rst = 0;
    @(negedge clk);
    do_write(0, ADDR_PWM_DUTY, 8'h80, 0);
    chk("t1_wait", r_wait, 0);
    chk("t1_busy", r_busy, 1);
    chk("t1_ncs_fall", r_ncs, 1);
    chk("t1_first_sclk", r_sclk, 5);
    chk("t1_ncs_low", r_low, 132);
    chk("t1_done", r_done, 136);
    chk("t1_ready_during", r_rdy, 0);
    @(negedge clk);
    chk("t1_ready_after", rdy[0], 1);
    chk("t1_duty", lb0[ADDR_PWM_DUTY], 8'h80);
    do_write(0, ADDR_EN_OUT_7_0, 8'hFF, 1);
    chk("t2a_done", r_done, 136);
    do_write(0, ADDR_EN_OUT_15_8, 8'h0F, 0);
    chk("t2b_wait", r_wait, 1);
    chk("t2b_done", r_done, 136);
    chk("t2_gap", mon[0].hi_run, 5);
    @(negedge clk);
    chk("t2_out_lo", lb0[ADDR_EN_OUT_7_0], 8'hFF);
    chk("t2_out_hi", lb0[ADDR_EN_OUT_15_8], 8'h0F);
    f0 = mon[0].frames;
    fork
      do_write(0, ADDR_EN_PWM_7_0, 8'h11, 0);
      begin
        repeat (30) @(negedge clk);
        vld[0] = 1'b1;
        addr = ADDR_EN_PWM_15_8;
        data = 8'h22;
        @(negedge clk);
        vld[0] = 1'b0;
      end
    join
    chk("t3_ready_during", r_rdy, 0);
    chk("t3_done", r_done, 136);
    repeat (40) @(negedge clk);
    chk("t3_frames", mon[0].frames, f0 + 1);
    chk("t3_pwm_lo", lb0[ADDR_EN_PWM_7_0], 8'h11);
    chk("t3_pwm_hi", lb0[ADDR_EN_PWM_15_8], 8'h00);
    saved = lb0[ADDR_PWM_DUTY];
    addr = ADDR_PWM_DUTY;
    data = 8'h3C;
    vld[0] = 1'b1;
    chk("t4_ready", rdy[0], 1);
    expq0.push_back({1'b1, ADDR_PWM_DUTY, 8'h3C});
    @(posedge clk);
    #1 vld[0] = 1'b0;
    for (int n = 0; n < 500 && mon[0].bits != 7; n++) @(negedge clk);
    chk("t4_rise7", mon[0].bits, 7);
    rst = 1;
    #1;
    chk("t4_ncs", ncs[0], 1);
    chk("t4_sclk", sclk[0], 0);
    chk("t4_busy", busy[0], 0);
    void'(expq0.pop_back());
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t4_duty_kept", lb0[ADDR_PWM_DUTY], saved);
    do_write(0, ADDR_PWM_DUTY, 8'h5A, 0);
    chk("t4_ncs_low", r_low, 132);
    chk("t4_done", r_done, 136);
    @(negedge clk);
    chk("t4_duty", lb0[ADDR_PWM_DUTY], 8'h5A);
    do_write(1, ADDR_EN_PWM_7_0, 8'hA5, 0);
    chk("t5_first_sclk", r_sclk, 3);
    chk("t5_ncs_low", r_low, 66);
    chk("t5_done", r_done, 67);
    @(negedge clk);
    chk("t5_pwm_lo", lb1[ADDR_EN_PWM_7_0], 8'hA5);
`ifdef SPI_CTRL_ADDR_CHECK_EN
    f0 = mon[0].frames;
    addr = 7'h05;
    data = 8'h33;
    vld[0] = 1'b1;
    chk("t6_ready", rdy[0], 1);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk("t6_err", err[0], 1);
    chk("t6_idle", rdy[0], 1);
    chk("t6_ncs", ncs[0], 1);
    n_low = 0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      n_low += int'(!ncs[0]);
      n_done += int'(done[0]);
    end
    chk("t6_no_ncs", n_low, 0);
    chk("t6_no_done", n_done, 0);
    chk("t6_frames", mon[0].frames, f0);
    chk("t6_err_once", mon[0].errs, 1);
    do_write(0, ADDR_EN_PWM_15_8, 8'h44, 0);
    chk("t6_done", r_done, 136);
    @(negedge clk);
    chk("t6_pwm_hi", lb0[ADDR_EN_PWM_15_8], 8'h44);
`else
    do_write(0, 7'h05, 8'h33, 0);
    chk("t6_done", r_done, 136);
    @(negedge clk);
    chk("t6_no_err", mon[0].errs, 0);
`endif
    chk("copi_stable0", mon[0].viol, 0);
    chk("copi_stable1", mon[1].viol, 0);
    chk("queue0_empty", expq0.size(), 0);
    chk("queue1_empty", expq1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_controller.md
# spi_controller

SPI write controller: the initiating end of the team's 16-bit SPI register-write protocol. It accepts one write request at a time (7-bit register address, 8-bit data) over a valid/ready handshake, then drives nCS, SCLK and COPI to send one frame MSB first in SPI mode 0. It sits in test harnesses and host-side logic that program the SPI register map: output enables, PWM enables and PWM duty cycle.

## Interface
- HALF_PERIOD, 4: clk cycles per SCLK half-period; minimum legal value 2. It must be large enough for the receiver's two-flop synchronizer plus edge detect.
- GAP_CYCLES, 4: minimum clk cycles nCS stays high between frames; minimum 1.
- MAX_ADDR, 7'h04: highest valid register address. Used only under SPI_CTRL_ADDR_CHECK_EN.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request present.
- req_ready  out  1  controller can accept; high exactly while in IDLE.
- req_addr  in  7  register address, sampled on acceptance.
- req_data  in  8  register data, sampled on acceptance.
- SCLK  out  1  serial clock, idle low.
- nCS  out  1  chip select, active low.
- COPI  out  1  serial data, controller to peripheral.
- busy  out  1  high from acceptance until the cycle done pulses.
- done  out  1  one-cycle pulse when a frame (and its gap) completes.
- err  out  1  one-cycle pulse on a rejected request; tied 0 without the macro.

## Operation
- Acceptance: a request is accepted in the cycle where req_valid && req_ready. Frame = {1'b1, req_addr, req_data} is latched into a 16-bit shift register. Bit 15 is the write flag.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
  - IDLE: nCS=1, SCLK=0, req_ready=1. Acceptance moves to SETUP.
  - SETUP: nCS=0, SCLK=0, COPI=frame[15]. Lasts HALF_PERIOD cycles, then goes to HIGH.
  - HIGH: SCLK=1 for HALF_PERIOD cycles. COPI is stable throughout. Increment bit counter (0..15) at exit. Go to LOW if fewer than 16 bits have been sent, otherwise HOLD.
  - LOW: SCLK=0. COPI takes the next bit on the first LOW cycle. Lasts HALF_PERIOD cycles, then HIGH.
  - HOLD: SCLK=0, nCS=0 for HALF_PERIOD cycles, then GAP.
  - GAP: nCS=1 for GAP_CYCLES cycles. Pulse done on the final cycle, then IDLE.
- Exactly 16 SCLK rising edges per frame. COPI never changes while SCLK=1.
- req_valid asserted outside IDLE is ignored, not queued. The requester holds it until ready.
- All outputs are registered; no glitches on SCLK, nCS or COPI.
- One phase counter of width $clog2(max(HALF_PERIOD, GAP_CYCLES)) is reloaded on every state change.
- Reset values: nCS=1, SCLK=0, COPI=0, req_ready=1 (IDLE), busy=0, done=0, err=0, shift register and counters 0.
- Reset mid-frame: outputs go to their reset values immediately (asynchronous), nCS rises, and the partial frame is abandoned. The peripheral discards it on nCS high. There is no resume.

## Timing
- nCS falls on the cycle after acceptance.
- First SCLK rise: 1 + HALF_PERIOD cycles after acceptance.
- nCS rises 33*HALF_PERIOD cycles after nCS falls.
- done pulses 33*HALF_PERIOD + GAP_CYCLES cycles after the acceptance cycle; req_ready is high the next cycle. Defaults give 136 cycles.
- Back-to-back throughput: one frame per 33*HALF_PERIOD + GAP_CYCLES + 1 cycles.
- A request accepted on the cycle immediately after done incurs no extra dead time.

## Configuration
- SPI_CTRL_ADDR_CHECK_EN defined:
  - An accepted request with req_addr > MAX_ADDR produces no frame. nCS stays high.
  - err pulses on the cycle after acceptance, and the FSM returns to IDLE that same cycle. done does not pulse.
- Undefined: every address is transmitted and err is constant 0.

## Structure
- Package spi_pkg holds:
  - FRAME_W=16, WRITE_BIT=15, ADDR_W=7, DATA_W=8.
  - Register address constants: ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04.
  - The controller FSM state enum.
- One sub-module is natural: spi_phase_timer. It is a loadable down-counter with a terminal-count pulse, used for SETUP/HIGH/LOW/HOLD/GAP durations.

## Test plan
- Write addr 0x04, data 0x80 (defaults) -> COPI samples 0x8480 MSB first on 16 SCLK rises; nCS low for 132 cycles; done at cycle 136; the SPI peripheral block in loopback shows pwm_duty_cycle=0x80.
- Two back-to-back requests (0x00/0xFF, then 0x01/0x0F) with req_valid held high -> second accepted on the cycle after first done; nCS high ≥ GAP_CYCLES between frames; both registers updated.
- req_valid pulsed while busy -> not accepted; no second frame; req_ready stays 0 until done.
- Assert rst after the 7th SCLK rise -> nCS=1, SCLK=0, busy=0 in the same cycle; loopback registers unchanged; the next request transmits a full 16-bit frame.
- HALF_PERIOD=2, GAP_CYCLES=1, write 0x02/0xA5 -> each SCLK phase 2 cycles; done at cycle 67; loopback en_reg_pwm_7_0=0xA5.
- With SPI_CTRL_ADDR_CHECK_EN, write addr 0x05 -> err pulse 1 cycle after acceptance, no nCS activity, no done; then addr 0x03 transmits normally.
